// File: rtl/key_pulse_gen_pkg.sv
// Shared definitions for the key pulse generator.
//
// Contents:
//   state_t                FSM states of the auto-repeat controller
//   DEF_DEBOUNCE_CYCLES    default debounce hold time, in clock cycles
//   DEF_REPEAT_DELAY       default press-to-first-repeat time, in cycles
//   DEF_REPEAT_PERIOD      default repeat-to-repeat time, in cycles
//   cnt_width()            bit width of a counter that must reach n-1
package key_pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

    // A counter that only ever reaches n-1 needs $clog2(n) bits; keep at
    // least one bit so a parameter of 1 still yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizer and debouncer for an active-low mechanical push-button.
//
// Ports:
//   clk    in   clock, all state on the rising edge
//   rst    in   synchronous active-high reset
//   key_n  in   raw asynchronous button, active-low, bouncing
//   level  out  debounced key state, 1 = pressed
//   rise   out  combinational: level goes 0->1 on the coming edge
//   fall   out  combinational: level goes 1->0 on the coming edge
module key_debounce
    import key_pulse_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned    W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [W-1:0]   LAST = W'(DEBOUNCE_CYCLES - 1);

    logic         sync1;
    logic         sync2;
    logic         s;
    logic         accept;
    logic [W-1:0] cnt;

    assign s      = ~sync2;
    assign accept = (s != level) && (cnt == LAST);
    assign rise   = accept && s;
    assign fall   = accept && !s;

    // Synchronizer flops clear to 0, so right after reset s reads as pressed
    // until the real key level has propagated; a released key is seen well
    // before the debounce interval could expire, a held key is accepted one
    // full interval after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_pulse_gen.sv
// Debounced push-button to single-cycle strobe, with optional auto-repeat.
// A press produces one pulse on the edge the debounced level rises; with
// auto-repeat enabled, further pulses follow after REPEAT_DELAY cycles and
// then every REPEAT_PERIOD cycles while the key stays held.
//
// Ports:
//   i_clk        in   clock, all state on the rising edge
//   i_rst        in   synchronous active-high reset
//   i_key_n      in   raw asynchronous button, active-low, bouncing
//   i_repeat_en  in   1 = auto-repeat while held, 0 = one pulse per press
//   o_level      out  debounced key state, 1 = pressed
//   o_pulse      out  one-cycle strobe per accepted press or repeat
//   o_held       out  1 while in the auto-repeat phase
module key_pulse_gen
    import key_pulse_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_pulse,
    output logic o_held
);

    // One counter serves both the delay and the period phases, so it is
    // sized for the larger of the two.
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                  : REPEAT_PERIOD;
    localparam int unsigned    RW          = cnt_width(RMAX);
    localparam logic [RW-1:0]  DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]  PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    state_t        state;
    state_t        state_next;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_next;
    logic          pulse_next;
    logic          level;
    logic          rise;
    logic          fall;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (i_clk),
        .rst   (i_rst),
        .key_n (i_key_n),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // The press pulse is registered on the same edge the debounced level
    // rises, so o_pulse and o_level go high together. A release being
    // accepted on the same edge as a repeat strobe cancels that strobe; the
    // state itself returns to IDLE on the following edge.
    always_comb begin
        state_next = state;
        rcnt_next  = rcnt;
        pulse_next = 1'b0;

        case (state)
            IDLE: begin
                rcnt_next = '0;
                if (rise) begin
                    pulse_next = 1'b1;
                    state_next = DELAY;
                end
            end

            DELAY: begin
                if (!level) begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                end else if (rcnt == DELAY_LAST) begin
                    // Without auto-repeat the counter parks here until release.
                    if (i_repeat_en) begin
                        pulse_next = !fall;
                        state_next = REPEAT;
                        rcnt_next  = '0;
                    end
                end else begin
                    rcnt_next = rcnt + 1'b1;
                end
            end

            REPEAT: begin
                if (!level) begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                end else if (rcnt == PERIOD_LAST) begin
                    pulse_next = i_repeat_en && !fall;
                    rcnt_next  = '0;
                end else begin
                    rcnt_next = rcnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                rcnt_next  = '0;
            end
        endcase

        // Keeps the strobe single-cycle even for delay/period values of 1.
        if (o_pulse) begin
            pulse_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            rcnt    <= '0;
            o_pulse <= 1'b0;
        end else begin
            state   <= state_next;
            rcnt    <= rcnt_next;
            o_pulse <= pulse_next;
        end
    end

    assign o_level = level;
    assign o_held  = (state == REPEAT);

endmodule

// File: tb/tb_key_pulse_gen.sv
// Self-checking bench for key_pulse_gen with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_key_pulse_gen;

    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int MAXE = 8192;

    logic clk = 1'b0;
    logic rst;
    logic key_n;
    logic en;
    logic lvl;
    logic pulse;
    logic held;

    key_pulse_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_key_n     (key_n),
        .i_repeat_en (en),
        .o_level     (lvl),
        .o_pulse     (pulse),
        .o_held      (held)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ne     = 0;

    // Per-edge record: inputs sampled at edge n, DUT outputs just after it,
    // and the reference model's expectation for the same edge.
    bit   rst_a [MAXE];
    bit   key_a [MAXE];
    bit   en_a  [MAXE];
    bit   lvl_m [MAXE];
    bit   pulse_m [MAXE];
    bit   held_m  [MAXE];
    logic lvl_o [MAXE];
    logic pulse_o [MAXE];
    logic held_o  [MAXE];

    int last_rst = -1;
    int rise_e   = -1;

    // Key level the debouncer sees (inverted) just before edge n: the key
    // sampled two edges earlier, or the "pressed" value right after reset.
    function automatic bit s_before(input int n);
        bit ks;
        if (n < 2) return 1'b1;
        ks = (rst_a[n-1] || rst_a[n-2]) ? 1'b0 : key_a[n-2];
        return ~ks;
    endfunction

    task automatic step(input bit r, input bit k, input bit e);
        int n;
        bit prev, lv, flip, entered;
        int kk;
        rst = r; key_n = k; en = e;
        @(posedge clk);
        #1;
        n = ne;
        if (n >= MAXE) begin
            $display("FAIL edge_budget recorded=%0d limit=%0d", n, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        rst_a[n] = r; key_a[n] = k; en_a[n] = e;
        lvl_o[n] = lvl; pulse_o[n] = pulse; held_o[n] = held;

        prev = (n == 0) ? 1'b0 : lvl_m[n-1];
        pulse_m[n] = 1'b0;
        held_m[n]  = 1'b0;
        if (r) begin
            lv       = 1'b0;
            last_rst = n;
            rise_e   = -1;
        end else begin
            // Level flips once the key has differed for DEB straight edges
            // since the last reset.
            flip = (n - DEB + 1 > last_rst);
            for (int j = 0; j < DEB; j++)
                if (s_before(n - j) == prev) flip = 1'b0;
            lv = flip ? ~prev : prev;
            if (!prev && lv) begin
                pulse_m[n] = 1'b1;
                rise_e     = n;
            end else if (prev && rise_e >= 0) begin
                kk      = n - rise_e;
                entered = (kk >= RD) && en_a[rise_e + RD];
                held_m[n] = entered;
                if (lv && en_a[n] &&
                    (kk == RD || (entered && kk > RD && (kk - RD) % RP == 0)))
                    pulse_m[n] = 1'b1;
            end else begin
                rise_e = -1;
            end
        end
        lvl_m[n] = lv;
        ne++;
    endtask

    task automatic hold_key(input int cycles, input bit e);
        repeat (cycles) step(1'b0, 1'b0, e);
    endtask

    task automatic free_key(input int cycles, input bit e);
        repeat (cycles) step(1'b0, 1'b1, e);
    endtask

    task automatic test_reset();
        int t0;
        t0 = ne;
        repeat (3) step(1'b1, 1'b1, 1'b0);
        free_key(8, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b1);
        free_key(10, 1'b0);
        for (int n = t0; n < ne; n++) begin
            if (rst_a[n]) begin
                checks++;
                if ({lvl_o[n], pulse_o[n], held_o[n]} !== 3'b000) begin
                    errors++;
                    $display("FAIL reset_outputs edge=%0d got=%b%b%b want=000",
                             n, lvl_o[n], pulse_o[n], held_o[n]);
                end
            end
            checks++;
            if ({lvl_o[n], pulse_o[n], held_o[n]} !== {lvl_m[n], pulse_m[n], held_m[n]}) begin
                errors++;
                $display("FAIL reset_trace edge=%0d got lvl/pulse/held=%b%b%b want=%b%b%b",
                         n, lvl_o[n], pulse_o[n], held_o[n], lvl_m[n], pulse_m[n], held_m[n]);
            end
        end
    endtask

    task automatic test_clean_press();
        int p, rise_at, cnt;
        p = ne;
        hold_key(30, 1'b0);
        free_key(15, 1'b0);
        rise_at = -1; cnt = 0;
        for (int n = p; n < ne; n++) begin
            if (lvl_o[n] === 1'b1 && rise_at < 0) rise_at = n;
            if (pulse_o[n] === 1'b1) cnt++;
            checks++;
            if ({lvl_o[n], pulse_o[n], held_o[n]} !== {lvl_m[n], pulse_m[n], held_m[n]}) begin
                errors++;
                $display("FAIL clean_trace edge=%0d got lvl/pulse/held=%b%b%b want=%b%b%b",
                         n, lvl_o[n], pulse_o[n], held_o[n], lvl_m[n], pulse_m[n], held_m[n]);
            end
        end
        checks++;
        if (rise_at != p + DEB + 1) begin
            errors++;
            $display("FAIL clean_latency rise_edge=%0d want=%0d", rise_at, p + DEB + 1);
        end
        checks++;
        if (cnt != 1) begin
            errors++;
            $display("FAIL clean_pulse_count got=%0d want=1", cnt);
        end
    endtask

    task automatic test_bounce();
        int p, pf, rise_at, cnt;
        p = ne;
        hold_key(3, 1'b0);
        free_key(1, 1'b0);
        pf = ne;
        hold_key(20, 1'b0);
        free_key(15, 1'b0);
        rise_at = -1; cnt = 0;
        for (int n = p; n < ne; n++) begin
            if (lvl_o[n] === 1'b1 && rise_at < 0) rise_at = n;
            if (pulse_o[n] === 1'b1) cnt++;
            checks++;
            if ({lvl_o[n], pulse_o[n], held_o[n]} !== {lvl_m[n], pulse_m[n], held_m[n]}) begin
                errors++;
                $display("FAIL bounce_trace edge=%0d got lvl/pulse/held=%b%b%b want=%b%b%b",
                         n, lvl_o[n], pulse_o[n], held_o[n], lvl_m[n], pulse_m[n], held_m[n]);
            end
        end
        checks++;
        if (rise_at != pf + DEB + 1) begin
            errors++;
            $display("FAIL bounce_latency rise_edge=%0d want=%0d", rise_at, pf + DEB + 1);
        end
        checks++;
        if (cnt != 1) begin
            errors++;
            $display("FAIL bounce_pulse_count got=%0d want=1", cnt);
        end
    endtask

    task automatic test_repeat();
        int p, t0, f;
        bit ep, eh;
        free_key(4, 1'b1);
        p = ne;
        hold_key(30, 1'b1);
        free_key(15, 1'b1);
        t0 = p + DEB + 1;
        f  = p + 30 + DEB + 1;
        for (int n = p; n < ne; n++) begin
            ep = (n == t0) || (n >= t0 + RD && n < f && (n - t0 - RD) % RP == 0);
            eh = (n >= t0 + RD) && (n <= f);
            checks++;
            if ({pulse_o[n], held_o[n]} !== {ep, eh}) begin
                errors++;
                $display("FAIL repeat_schedule edge=%0d got pulse/held=%b%b want=%b%b",
                         n, pulse_o[n], held_o[n], ep, eh);
            end
            checks++;
            if ({lvl_o[n], pulse_o[n], held_o[n]} !== {lvl_m[n], pulse_m[n], held_m[n]}) begin
                errors++;
                $display("FAIL repeat_trace edge=%0d got lvl/pulse/held=%b%b%b want=%b%b%b",
                         n, lvl_o[n], pulse_o[n], held_o[n], lvl_m[n], pulse_m[n], held_m[n]);
            end
        end
    endtask

    task automatic test_release_phase();
        int p, f;
        for (int h = 12; h <= 15; h++) begin
            free_key(12, 1'b1);
            p = ne;
            hold_key(h, 1'b1);
            free_key(12, 1'b1);
            f = p + h + DEB + 1;
            checks++;
            if (pulse_o[p + DEB + 1 + RD] !== 1'b1) begin
                errors++;
                $display("FAIL release_first_repeat hold=%0d got=%b want=1",
                         h, pulse_o[p + DEB + 1 + RD]);
            end
            checks++;
            if (held_o[f + 1] !== 1'b0) begin
                errors++;
                $display("FAIL release_idle hold=%0d got held=%b want=0", h, held_o[f + 1]);
            end
            for (int n = p; n < ne; n++) begin
                if (n >= f) begin
                    checks++;
                    if (pulse_o[n] !== 1'b0) begin
                        errors++;
                        $display("FAIL release_no_pulse hold=%0d edge=%0d got=%b want=0",
                                 h, n, pulse_o[n]);
                    end
                end
                checks++;
                if ({lvl_o[n], pulse_o[n], held_o[n]} !== {lvl_m[n], pulse_m[n], held_m[n]}) begin
                    errors++;
                    $display("FAIL release_trace edge=%0d got lvl/pulse/held=%b%b%b want=%b%b%b",
                             n, lvl_o[n], pulse_o[n], held_o[n], lvl_m[n], pulse_m[n], held_m[n]);
                end
            end
        end
    endtask

    task automatic test_repeat_disable();
        int p, f;
        free_key(12, 1'b1);
        p = ne;
        hold_key(25, 1'b1);
        hold_key(20, 1'b0);
        free_key(12, 1'b0);
        f = p + 45 + DEB + 1;
        for (int n = p; n < ne; n++) begin
            if (n >= p + 25) begin
                checks++;
                if (pulse_o[n] !== 1'b0) begin
                    errors++;
                    $display("FAIL disable_no_pulse edge=%0d got=%b want=0", n, pulse_o[n]);
                end
            end
            if (n >= p + 25 && n <= f) begin
                checks++;
                if (held_o[n] !== 1'b1) begin
                    errors++;
                    $display("FAIL disable_held edge=%0d got=%b want=1", n, held_o[n]);
                end
            end
            checks++;
            if ({lvl_o[n], pulse_o[n], held_o[n]} !== {lvl_m[n], pulse_m[n], held_m[n]}) begin
                errors++;
                $display("FAIL disable_trace edge=%0d got lvl/pulse/held=%b%b%b want=%b%b%b",
                         n, lvl_o[n], pulse_o[n], held_o[n], lvl_m[n], pulse_m[n], held_m[n]);
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        int p, r1, rise_at;
        free_key(12, 1'b1);
        p = ne;
        hold_key(20, 1'b1);
        r1 = ne;
        repeat (2) step(1'b1, 1'b0, 1'b1);
        hold_key(25, 1'b1);
        free_key(12, 1'b1);
        checks++;
        if (held_o[r1 - 1] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_held got=%b want=1", held_o[r1 - 1]);
        end
        for (int n = r1; n < r1 + 2; n++) begin
            checks++;
            if ({lvl_o[n], pulse_o[n], held_o[n]} !== 3'b000) begin
                errors++;
                $display("FAIL midreset_outputs edge=%0d got=%b%b%b want=000",
                         n, lvl_o[n], pulse_o[n], held_o[n]);
            end
        end
        rise_at = -1;
        for (int n = r1 + 2; n < ne; n++)
            if (lvl_o[n] === 1'b1 && rise_at < 0) rise_at = n;
        checks++;
        if (rise_at != r1 + 1 + DEB) begin
            errors++;
            $display("FAIL midreset_latency rise_edge=%0d want=%0d", rise_at, r1 + 1 + DEB);
        end
        checks++;
        if (pulse_o[r1 + 1 + DEB] !== 1'b1 || pulse_o[r1 + 1 + DEB + RD] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_restart got press/repeat=%b%b want=11",
                     pulse_o[r1 + 1 + DEB], pulse_o[r1 + 1 + DEB + RD]);
        end
        for (int n = p; n < ne; n++) begin
            checks++;
            if ({lvl_o[n], pulse_o[n], held_o[n]} !== {lvl_m[n], pulse_m[n], held_m[n]}) begin
                errors++;
                $display("FAIL midreset_trace edge=%0d got lvl/pulse/held=%b%b%b want=%b%b%b",
                         n, lvl_o[n], pulse_o[n], held_o[n], lvl_m[n], pulse_m[n], held_m[n]);
            end
        end
    endtask

    task automatic test_random();
        int  p;
        bit  e;
        e = 1'b0;
        p = ne;
        for (int i = 0; i < 30; i++) begin
            // Let the level settle low before changing the repeat mode.
            free_key(8, e);
            e = 1'($urandom_range(0, 1));
            free_key(int'($urandom_range(0, 8)), e);
            if ($urandom_range(0, 1) == 1) begin
                hold_key(int'($urandom_range(1, 3)), e);
                free_key(int'($urandom_range(1, 3)), e);
            end
            hold_key(int'($urandom_range(1, 40)), e);
            if ($urandom_range(0, 1) == 1) begin
                free_key(int'($urandom_range(1, 3)), e);
                hold_key(int'($urandom_range(1, 3)), e);
            end
        end
        free_key(12, e);
        for (int n = p; n < ne; n++) begin
            checks++;
            if ({lvl_o[n], pulse_o[n], held_o[n]} !== {lvl_m[n], pulse_m[n], held_m[n]}) begin
                errors++;
                $display("FAIL random_trace edge=%0d got lvl/pulse/held=%b%b%b want=%b%b%b",
                         n, lvl_o[n], pulse_o[n], held_o[n], lvl_m[n], pulse_m[n], held_m[n]);
            end
            checks++;
            if (pulse_o[n] === 1'b1 && pulse_o[n - 1] === 1'b1) begin
                errors++;
                $display("FAIL random_pulse_width edge=%0d got two consecutive pulses want one", n);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        key_n = 1'b1;
        en    = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_release_phase();
        test_repeat_disable();
        test_reset_mid_repeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
